cra_sequencer: RTL and testbench

CRA_SEQUENCER -- requirements
Module: cra_sequencer

---
 rtl/cra_sequencer.sv | 174 +++++++++++++++++
 tb/tb_cra_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/cra_sequencer.sv
// rtl/cra_sequencer.sv - microcode address sequencer with 16-deep call/return stack
//
// Purpose: selects the next control-RAM address every cycle from the microword
// jump field, the instruction-decode jump, operand mode, normalize code or the
// return stack, and keeps a 16-entry LIFO of return addresses with sticky
// overflow/underflow flags.
//
// Optional feature: define CRA_DIAG_EBUS_EN to compile in the diagnostic EBUS
// readback; otherwise drivingEBUS and ebusOut are tied to zero.
//
// Ports:
//   clk              sole clock, rising edge
//   reset            synchronous active-high reset
//   CRAM_J[10:0]     microword jump-base address
//   CRAM_DISP[2:0]   dispatch select (0 J, 1 DRAM_J, 2 J|A, 3 return, 4 J|norm)
//   CRAM_CALL        push current CRADR
//   skipCond         ORed into next address bit 0
//   DRAM_J[10:0]     instruction-decode jump address
//   DRAM_A[2:0]      operand-fetch mode
//   norm[2:0]        normalize priority code
//   stall            hold all state
//   diagLoadCRADR    console forced load of CRADR from diagAddr
//   diagAddr[10:0]   forced address
//   diagReadFunc14X  diag read strobe
//   diag[4:6]        diag read select
//   CRADR[10:0]      registered current microcode address
//   stackDepth[4:0]  entries on stack, 0..16
//   stackOverflow    sticky overflow flag
//   stackUnderflow   sticky underflow flag
//   drivingEBUS      diag driving EBUS
//   ebusOut[0:35]    diag readback

module cra_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] CRAM_J,
  input  logic [2:0]  CRAM_DISP,
  input  logic        CRAM_CALL,
  input  logic        skipCond,
  input  logic [10:0] DRAM_J,
  input  logic [2:0]  DRAM_A,
  input  logic [2:0]  norm,
  input  logic        stall,
  input  logic        diagLoadCRADR,
  input  logic [10:0] diagAddr,
  input  logic        diagReadFunc14X,
  input  logic [4:6]  diag,
  output logic [10:0] CRADR,
  output logic [4:0]  stackDepth,
  output logic        stackOverflow,
  output logic        stackUnderflow,
  output logic        drivingEBUS,
  output logic [0:35] ebusOut
);

  logic [10:0] cradr_q, cradr_d;
  logic [4:0]  depth_q, depth_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;
  logic [10:0] stack_q [16];

  logic        wr_en;
  logic [3:0]  wr_idx;
  logic [3:0]  top_idx;
  logic [10:0] top_val;
  logic [10:0] disp_addr;
  logic [10:0] next_addr;
  logic        is_ret;

  // At depth 16 the low nibble wraps to 0, so depth-1 still lands on entry 15.
  assign top_idx = depth_q[3:0] - 4'd1;
  // An empty stack pops as zero.
  assign top_val = (depth_q == 5'd0) ? 11'd0 : stack_q[top_idx];
  assign is_ret  = (CRAM_DISP == 3'd3);

  always_comb begin
    disp_addr = CRAM_J;
    case (CRAM_DISP)
      3'd1:    disp_addr = DRAM_J;
      3'd2:    disp_addr = {CRAM_J[10:3], DRAM_A};
      3'd3:    disp_addr = top_val | {7'b0, CRAM_J[3:0]};
      3'd4:    disp_addr = {CRAM_J[10:3], norm};
      default: disp_addr = CRAM_J;
    endcase
    next_addr = {disp_addr[10:1], disp_addr[0] | skipCond};
  end

  always_comb begin
    cradr_d = cradr_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    wr_en   = 1'b0;
    wr_idx  = 4'd0;
    if (diagLoadCRADR) begin
      // Console load wins over stall and dispatch and never touches the stack.
      cradr_d = diagAddr;
    end else if (!stall) begin
      cradr_d = next_addr;
      if (is_ret && CRAM_CALL) begin
        // Return-and-call swaps the top entry; on an empty stack it behaves
        // as an underflowing pop followed by a push.
        wr_en = 1'b1;
        if (depth_q == 5'd0) begin
          unf_d   = 1'b1;
          wr_idx  = 4'd0;
          depth_d = 5'd1;
        end else begin
          wr_idx = top_idx;
        end
      end else if (is_ret) begin
        if (depth_q == 5'd0) unf_d = 1'b1;
        else                 depth_d = depth_q - 5'd1;
      end else if (CRAM_CALL) begin
        if (depth_q == 5'd16) begin
          ovf_d = 1'b1;
        end else begin
          wr_en   = 1'b1;
          wr_idx  = depth_q[3:0];
          depth_d = depth_q + 5'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cradr_q <= 11'd0;
      depth_q <= 5'd0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      cradr_q <= cradr_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage carries no reset; a reset edge only suppresses the write.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) stack_q[wr_idx] <= cradr_q;
  end

  assign CRADR          = cradr_q;
  assign stackDepth     = depth_q;
  assign stackOverflow  = ovf_q;
  assign stackUnderflow = unf_q;

`ifdef CRA_DIAG_EBUS_EN
  logic [5:0] diag_field;

  always_comb begin
    diag_field = 6'd0;
    case (diag)
      3'd0:    diag_field = cradr_q[10:5];
      3'd1:    diag_field = {cradr_q[4:0], ovf_q};
      3'd2:    diag_field = {unf_q, depth_q};
      3'd3:    diag_field = top_val[10:5];
      3'd4:    diag_field = {top_val[4:0], 1'b0};
      default: diag_field = 6'd0;
    endcase
  end

  assign drivingEBUS = diagReadFunc14X;
  assign ebusOut     = diagReadFunc14X ? {diag_field, 30'd0} : 36'd0;
`else
  logic unused_diag;
  assign unused_diag = ^{diagReadFunc14X, diag};
  assign drivingEBUS = 1'b0;
  assign ebusOut     = 36'd0;
`endif

endmodule

// File: tb/tb_cra_sequencer.sv
// tb/tb_cra_sequencer.sv - directed self-checking bench for cra_sequencer

module tb_cra_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] CRAM_J;
  logic [2:0]  CRAM_DISP;
  logic        CRAM_CALL;
  logic        skipCond;
  logic [10:0] DRAM_J;
  logic [2:0]  DRAM_A;
  logic [2:0]  norm;
  logic        stall;
  logic        diagLoadCRADR;
  logic [10:0] diagAddr;
  logic        diagReadFunc14X;
  logic [4:6]  diag;
  logic [10:0] CRADR;
  logic [4:0]  stackDepth;
  logic        stackOverflow;
  logic        stackUnderflow;
  logic        drivingEBUS;
  logic [0:35] ebusOut;

  int total = 0;
  int bad   = 0;

  cra_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .CRAM_J          (CRAM_J),
    .CRAM_DISP       (CRAM_DISP),
    .CRAM_CALL       (CRAM_CALL),
    .skipCond        (skipCond),
    .DRAM_J          (DRAM_J),
    .DRAM_A          (DRAM_A),
    .norm            (norm),
    .stall           (stall),
    .diagLoadCRADR   (diagLoadCRADR),
    .diagAddr        (diagAddr),
    .diagReadFunc14X (diagReadFunc14X),
    .diag            (diag),
    .CRADR           (CRADR),
    .stackDepth      (stackDepth),
    .stackOverflow   (stackOverflow),
    .stackUnderflow  (stackUnderflow),
    .drivingEBUS     (drivingEBUS),
    .ebusOut         (ebusOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0o exp=%0o", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic state_chk(input string tag, input logic [10:0] a, input logic [4:0] d,
                           input logic o, input logic u);
    chk({tag, ".cradr"}, 36'(CRADR), 36'(a));
    chk({tag, ".depth"}, 36'(stackDepth), 36'(d));
    chk({tag, ".ovf"}, 36'(stackOverflow), 36'(o));
    chk({tag, ".unf"}, 36'(stackUnderflow), 36'(u));
  endtask

  initial begin
    logic [10:0] exp_e;
    reset = 1'b1; CRAM_J = '0; CRAM_DISP = '0; CRAM_CALL = 1'b0; skipCond = 1'b0;
    DRAM_J = '0; DRAM_A = '0; norm = '0; stall = 1'b0; diagLoadCRADR = 1'b0;
    diagAddr = '0; diagReadFunc14X = 1'b0; diag = 3'd0;
    step(); step();
    reset = 1'b0;
    state_chk("reset", 11'o0, 5'd0, 1'b0, 1'b0);
    chk("reset.drv", 36'(drivingEBUS), 36'd0);
    chk("reset.ebus", 36'(ebusOut), 36'd0);

    // Jump with skip
    CRAM_J = 11'o1234; skipCond = 1'b1; step();
    chk("jump_skip", 36'(CRADR), 36'(11'o1235));

    // Call / return
    skipCond = 1'b0; CRAM_J = 11'o100; step();
    CRAM_CALL = 1'b1; CRAM_J = 11'o200; step();
    state_chk("call", 11'o200, 5'd1, 1'b0, 1'b0);
    CRAM_CALL = 1'b0; CRAM_DISP = 3'd3; CRAM_J = 11'o2; step();
    state_chk("ret", 11'o102, 5'd0, 1'b0, 1'b0);

    // Operand mode and normalize dispatch
    CRAM_DISP = 3'd2; CRAM_J = 11'o1770; DRAM_A = 3'd5; step();
    chk("disp_a", 36'(CRADR), 36'(11'o1775));
    CRAM_DISP = 3'd4; norm = 3'd3; step();
    chk("disp_norm", 36'(CRADR), 36'(11'o1773));
    CRAM_DISP = 3'd6; CRAM_J = 11'o55; step();
    chk("disp6_as0", 36'(CRADR), 36'(11'o55));
    CRAM_DISP = 3'd1; DRAM_J = 11'o1400; skipCond = 1'b1; step();
    chk("dram_skip", 36'(CRADR), 36'(11'o1401));
    skipCond = 1'b0; CRAM_DISP = 3'd0; step();
    chk("back_j", 36'(CRADR), 36'(11'o55));

    // Stall, then release, then console load over stall
    CRAM_DISP = 3'd1; DRAM_J = 11'o1400; stall = 1'b1; CRAM_CALL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      state_chk("stall", 11'o55, 5'd0, 1'b0, 1'b0);
    end
    CRAM_CALL = 1'b0; stall = 1'b0; step();
    chk("unstall", 36'(CRADR), 36'(11'o1400));
    stall = 1'b1; diagLoadCRADR = 1'b1; diagAddr = 11'o777; CRAM_CALL = 1'b1; step();
    state_chk("diagload", 11'o777, 5'd0, 1'b0, 1'b0);
    stall = 1'b0; diagLoadCRADR = 1'b0;

    // 17 calls: pushes 0o777, 0o100..0o116; the 17th is dropped
    CRAM_DISP = 3'd0; CRAM_CALL = 1'b1;
    for (int k = 0; k < 17; k++) begin
      CRAM_J = 11'(11'o100 + k);
      step();
    end
    state_chk("fill", 11'o120, 5'd16, 1'b1, 1'b0);

    CRAM_CALL = 1'b0; CRAM_DISP = 3'd3; CRAM_J = 11'o0;
    for (int i = 0; i < 16; i++) begin
      step();
      exp_e = (i == 15) ? 11'o777 : 11'(11'o100 + 14 - i);
      chk($sformatf("drain%0d.cradr", i), 36'(CRADR), 36'(exp_e));
      chk($sformatf("drain%0d.depth", i), 36'(stackDepth), 36'(15 - i));
    end
    CRAM_J = 11'o5; step();
    state_chk("underflow", 11'o5, 5'd0, 1'b1, 1'b1);

    // Return-and-call swaps the top
    CRAM_DISP = 3'd0; CRAM_CALL = 1'b1; CRAM_J = 11'o300; step();
    state_chk("swap_call", 11'o300, 5'd1, 1'b1, 1'b1);
    CRAM_DISP = 3'd3; CRAM_J = 11'o0; step();
    state_chk("swap", 11'o5, 5'd1, 1'b1, 1'b1);
    CRAM_CALL = 1'b0; step();
    state_chk("swap_ret", 11'o300, 5'd0, 1'b1, 1'b1);

    // Reset clears sticky flags; return-and-call on empty stack
    reset = 1'b1; step(); reset = 1'b0;
    state_chk("reset2", 11'o0, 5'd0, 1'b0, 1'b0);
    CRAM_DISP = 3'd0; CRAM_J = 11'o400; step();
    CRAM_DISP = 3'd3; CRAM_CALL = 1'b1; CRAM_J = 11'o3; step();
    state_chk("retcall0", 11'o3, 5'd1, 1'b0, 1'b1);
    CRAM_CALL = 1'b0; CRAM_J = 11'o0; step();
    state_chk("retcall0_ret", 11'o400, 5'd0, 1'b0, 1'b1);

    // Reset mid-call and during stall
    CRAM_DISP = 3'd0; CRAM_CALL = 1'b1; CRAM_J = 11'o10; step();
    stall = 1'b1; reset = 1'b1; step(); reset = 1'b0; stall = 1'b0;
    state_chk("reset_mid", 11'o0, 5'd0, 1'b0, 1'b0);

    // Underflow then two calls: depth 2, top 0o1234
    CRAM_CALL = 1'b0; CRAM_DISP = 3'd3; CRAM_J = 11'o7; step();
    CRAM_DISP = 3'd0; CRAM_CALL = 1'b1; CRAM_J = 11'o1234; step();
    CRAM_J = 11'o40; step();
    CRAM_CALL = 1'b0; stall = 1'b1;
    state_chk("diag_setup", 11'o40, 5'd2, 1'b0, 1'b1);
    chk("ebus_off", 36'(ebusOut), 36'd0);
    diagReadFunc14X = 1'b1; diag = 3'd2; #1;
`ifdef CRA_DIAG_EBUS_EN
    chk("ebus_d2", 36'(ebusOut), {6'b100010, 30'd0});
    chk("ebus_drv", 36'(drivingEBUS), 36'd1);
    diag = 3'd3; #1;
    chk("ebus_d3", 36'(ebusOut), {6'b010100, 30'd0});
    diag = 3'd4; #1;
    chk("ebus_d4", 36'(ebusOut), {6'b111000, 30'd0});
    diag = 3'd0; #1;
    chk("ebus_d0", 36'(ebusOut), {6'b000001, 30'd0});
`else
    chk("ebus_d2", 36'(ebusOut), 36'd0);
    chk("ebus_drv", 36'(drivingEBUS), 36'd0);
`endif
    diagReadFunc14X = 1'b0; stall = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
